bit_serializer: RTL

Upstream stage for the serial divisibility checker. Accepts parallel words over a valid/ready handshake and shifts each word out MSB-first, one bit per accepted output beat, with start/end-of-word markers. The divisibility FSM consumes `out_bit` as its serial input, with `out_ready` tied high. It uses `out_sof` to know when to restart its residue.

---
 rtl/bit_ser_pkg.sv | 16 +
 rtl/bit_ser_hold.sv | 48 ++++
 rtl/bit_serializer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bit_ser_pkg.sv
// Shared types and sizing helpers for the bit serializer.
package bit_ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int BIT_SER_WIDTH_DEFAULT = 8;

    // Width of the bit index counter that runs WIDTH-1 down to 0.
    function automatic int bit_idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_ser_hold.sv
// One-word holding register with full flag; lets the serializer accept the
// next word while the current one is still shifting.
module bit_ser_hold
    import bit_ser_pkg::*;
#(
    parameter int WIDTH = BIT_SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state for the holding slot; pop and push never coincide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end else begin
            full_d = full_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= {WIDTH{1'b0}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, with SOF/EOF markers.
// Define BIT_SERIALIZER_SKID_EN to add a one-word hold register for gapless words.
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int WIDTH = BIT_SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_sof,
    output logic             out_eof
);

    localparam int IDX_W = bit_idx_w(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic in_hs_s;
    logic beat_s;
    logic last_s;

`ifdef BIT_SERIALIZER_SKID_EN
    logic             hold_full_s;
    logic             hold_push_s;
    logic             hold_pop_s;
    logic [WIDTH-1:0] hold_data_s;

    bit_ser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (hold_push_s),
        .pop_i  (hold_pop_s),
        .data_i (in_data),
        .data_o (hold_data_s),
        .full_o (hold_full_s)
    );

    assign in_ready = rst_n & ~hold_full_s;
`else
    assign in_ready = rst_n & (state_q == IDLE);
`endif

    assign in_hs_s = in_valid & in_ready;
    assign beat_s  = out_valid & out_ready;
    assign last_s  = (idx_q == IDX_ZERO);

    // Next-state: load, shift, and end-of-word reload/return decisions.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
`ifdef BIT_SERIALIZER_SKID_EN
        hold_push_s = 1'b0;
        hold_pop_s  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_hs_s) begin
                    shreg_d = in_data;
                    idx_d   = IDX_TOP;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (beat_s && !last_s) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    idx_d   = idx_q - IDX_ONE;
                end else if (beat_s) begin
`ifdef BIT_SERIALIZER_SKID_EN
                    if (hold_full_s) begin
                        shreg_d    = hold_data_s;
                        idx_d      = IDX_TOP;
                        hold_pop_s = 1'b1;
                    end else if (in_hs_s) begin
                        shreg_d = in_data;
                        idx_d   = IDX_TOP;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = SHIFT;
                end
`ifdef BIT_SERIALIZER_SKID_EN
                // A word arriving on the final beat bypasses the hold slot.
                if (in_hs_s && !(beat_s && last_s)) begin
                    hold_push_s = 1'b1;
                end else begin
                    hold_push_s = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= {WIDTH{1'b0}};
            idx_q   <= IDX_ZERO;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = (state_q == SHIFT);
    assign out_bit   = out_valid & shreg_q[WIDTH-1];
    assign out_sof   = out_valid & (idx_q == IDX_TOP);
    assign out_eof   = out_valid & (idx_q == IDX_ZERO);

endmodule
